// File: rtl/rx_front_end_if.sv
// rx_front_end_if: serial line input and receive-datapath strobes of the UART receive front end
interface rx_front_end_if;
  logic RX_IN;
  logic sample_out_reg;
  logic SIPO_EN;
  logic PAR_CHECK_EN;
  logic STOP_CHECK_EN;
  logic RX_CHECK_EN;
  logic start_glitch;
  logic busy;
  modport master (
    input  RX_IN,
    output sample_out_reg, SIPO_EN, PAR_CHECK_EN, STOP_CHECK_EN, RX_CHECK_EN, start_glitch, busy
  );
  modport slave (
    output RX_IN,
    input  sample_out_reg, SIPO_EN, PAR_CHECK_EN, STOP_CHECK_EN, RX_CHECK_EN, start_glitch, busy
  );
endinterface

// File: rtl/rx_front_end.sv
// rx_front_end: oversampling UART receive front end with start qualification, 2-of-3 mid-bit vote and datapath strobes
module rx_front_end #(
  parameter int DATA_WIDTH = 4,
  parameter int PRESCALE   = 8
) (
  input logic           clk,
  input logic           rst,
  rx_front_end_if.master bus
);
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [EW-1:0] E_STOP = EW'(PRESCALE / 2 + 2);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_t;
  state_t state, state_nx;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic armed;
  logic [1:0] smp;
  logic run, run_nx, bit_end, vote, hit;
  logic sipo_d, par_d, stop_d, glitch_d;
  logic sample_q, sipo_q, par_q, stop_q, glitch_q;
  assign run     = state inside {START, DATA, PARITY, STOP};
  assign run_nx  = state_nx inside {START, DATA, PARITY, STOP};
  assign bit_end = edge_cnt == E_LAST;
  // third vote sample is the live line during the last capture cycle
  assign vote    = (smp[0] & smp[1]) | (bus.RX_IN & (smp[0] | smp[1]));
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = armed && !bus.RX_IN ? START : IDLE;
      START:   state_nx = edge_cnt == E_S2 && vote ? IDLE : bit_end ? DATA : START;
      DATA:    state_nx = bit_end && bit_cnt == B_LAST ? PARITY : DATA;
      PARITY:  state_nx = bit_end ? STOP : PARITY;
      STOP:    state_nx = edge_cnt == E_STOP ? CHECK : STOP;
      CHECK:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    hit      = run && edge_cnt == E_S2;
    sipo_d   = hit && state == DATA;
    par_d    = hit && state == PARITY;
    stop_d   = hit && state == STOP;
    glitch_d = hit && state == START && vote;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      armed    <= 1'b0;
      smp      <= 2'b11;
    end else begin
      edge_cnt <= run && run_nx && !bit_end ? edge_cnt + 1'b1 : '0;
      bit_cnt  <= state != DATA ? '0 : bit_end ? bit_cnt + 1'b1 : bit_cnt;
      // a line that has not been seen high since the last frame cannot start a new one
      armed    <= state == IDLE && state_nx == IDLE ? armed | bus.RX_IN : 1'b0;
      smp[0]   <= edge_cnt == E_S0 ? bus.RX_IN : smp[0];
      smp[1]   <= edge_cnt == E_S1 ? bus.RX_IN : smp[1];
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sample_q <= 1'b1;
      sipo_q   <= 1'b0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      sample_q <= hit ? vote : sample_q;
      sipo_q   <= sipo_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      glitch_q <= glitch_d;
    end
  assign bus.sample_out_reg = sample_q;
  assign bus.SIPO_EN        = sipo_q;
  assign bus.PAR_CHECK_EN   = par_q;
  assign bus.STOP_CHECK_EN  = stop_q;
  assign bus.RX_CHECK_EN    = state == CHECK;
  assign bus.start_glitch   = glitch_q;
  assign bus.busy           = state != IDLE;
endmodule

// File: tb/tb_rx_front_end.sv
// tb_rx_front_end: directed UART frames against a scoreboard of expected strobe cycles and voted samples
module tb_rx_front_end;
  localparam int DW = 4;
  localparam int PS = 8;
  localparam int M  = PS / 2 + 3;
  localparam int FL = PS * (DW + 3);
  logic clk = 1'b0;
  logic rst = 1'b0;
  rx_front_end_if bus();
  rx_front_end #(.DATA_WIDTH(DW), .PRESCALE(PS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int c; logic [4:0] k; logic s;} ev_t;
  ev_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  function automatic logic [4:0] obs_vec();
    return {bus.start_glitch, bus.RX_CHECK_EN, bus.STOP_CHECK_EN, bus.PAR_CHECK_EN, bus.SIPO_EN};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic monitor();
    logic [4:0] exp;
    exp = (q.size() > 0 && q[0].c == cyc) ? q[0].k : 5'b0;
    chk("strobes", 32'(obs_vec()), 32'(exp));
    if (exp != 5'b0) begin
      if (exp[2:0] != 3'b0) chk("sample", 32'(bus.sample_out_reg), 32'(q[0].s));
      void'(q.pop_front());
    end
  endtask
  task automatic tick(input logic v);
    @(posedge clk);
    cyc++;
    #1 bus.RX_IN = v;
    @(negedge clk);
    monitor();
  endtask
  // detection happens on the first driven cycle; caller guarantees the line was high beforehand
  task automatic frame(input logic [DW-1:0] d, input logic p, input logic s, input bit glitch, input int upto);
    int dc, b, o;
    logic v;
    dc = cyc + 1;
    for (int i = 0; i < DW; i++) q.push_back('{dc + M + PS * (i + 1), 5'b00001, d[i]});
    q.push_back('{dc + M + PS * (DW + 1), 5'b00010, p});
    q.push_back('{dc + M + PS * (DW + 2), 5'b00100, s});
    q.push_back('{dc + M + PS * (DW + 2) + 1, 5'b01000, 1'b0});
    for (int t = 0; t < upto; t++) begin
      b = t / PS;
      o = t % PS;
      v = b == 0 ? 1'b0 : b <= DW ? d[b-1] : b == DW + 1 ? p : s;
      if (glitch && b >= 1 && b <= DW && o == PS / 2 + 1) v = ~v;
      tick(v);
      if (t == 0) chk("busy_at_D", 32'(bus.busy), 0);
      if (t == 1) chk("busy_rise", 32'(bus.busy), 1);
    end
  endtask
  task automatic tail();
    tick(1'b1);
    chk("busy_check_cycle", 32'(bus.busy), 1);
    tick(1'b1);
    chk("busy_fall", 32'(bus.busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.RX_IN = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sample", 32'(bus.sample_out_reg), 1);
    chk("reset_strobes", 32'(obs_vec()), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    rst = 1'b1;
    repeat (3) tick(1'b1);
    frame(4'b1010, 1'b1, 1'b1, 1'b0, FL);
    tail();
    frame(4'b0110, 1'b0, 1'b1, 1'b0, FL);
    tail();
    repeat (3) tick(1'b1);
    q.push_back('{cyc + 1 + M, 5'b10000, 1'b0});
    repeat (3) tick(1'b0);
    repeat (4) tick(1'b1);
    chk("glitch_busy", 32'(bus.busy), 1);
    repeat (11) tick(1'b0);
    chk("glitch_idle_low", 32'(bus.busy), 0);
    repeat (2) tick(1'b1);
    frame(4'b0011, 1'b0, 1'b1, 1'b0, FL);
    tail();
    frame(4'b1010, 1'b0, 1'b0, 1'b0, FL);
    repeat (20) tick(1'b0);
    chk("stop_err_no_retrigger", 32'(bus.busy), 0);
    tick(1'b1);
    frame(4'b0101, 1'b0, 1'b1, 1'b0, FL);
    tail();
    frame(4'b1010, 1'b1, 1'b1, 1'b1, FL);
    tail();
    frame(4'b0000, 1'b0, 1'b1, 1'b0, 25);
    chk("pre_reset_sample", 32'(bus.sample_out_reg), 0);
    #2 rst = 1'b0;
    #1;
    chk("async_sample", 32'(bus.sample_out_reg), 1);
    chk("async_strobes", 32'(obs_vec()), 0);
    chk("async_busy", 32'(bus.busy), 0);
    q.delete();
    repeat (3) tick(1'b1);
    rst = 1'b1;
    repeat (3) tick(1'b1);
    frame(4'b1100, 1'b0, 1'b1, 1'b0, FL);
    tail();
    repeat (4) tick(1'b1);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_front_end.md
# rx_front_end

UART receive front end: oversamples the raw serial line, detects and qualifies the start bit, majority-votes each bit at mid-bit, and sequences the receive datapath. It sits directly upstream of the receive datapath, which holds the SIPO, parity checker, stop checker and output check. It drives that datapath's serial sample and its `SIPO_EN`, `PAR_CHECK_EN`, `STOP_CHECK_EN` and `RX_CHECK_EN` strobes. Frame format is fixed: 1 start bit, DATA_WIDTH data bits LSB first, 1 parity bit, 1 stop bit.

## Interface
- DATA_WIDTH, 4, data bits per frame; must equal the datapath's DATA_WIDTH.
- PRESCALE, 8, clk cycles per bit; even, ≥ 6.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-low reset.
- RX_IN  in  1  raw serial line; idles high; pre-synchronised to clk.
- sample_out_reg  out  1  majority-voted value of the most recent bit.
- SIPO_EN  out  1  one-cycle strobe per data bit.
- PAR_CHECK_EN  out  1  one-cycle strobe for the parity bit.
- STOP_CHECK_EN  out  1  one-cycle strobe for the stop bit.
- RX_CHECK_EN  out  1  one-cycle strobe, one cycle after STOP_CHECK_EN.
- start_glitch  out  1  one-cycle pulse when a start bit is rejected.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP, CHECK.
- **edge_cnt:** width $clog2(PRESCALE). Runs 0..PRESCALE-1 in START, DATA, PARITY and STOP. Wraps to 0 at the end of each bit and advances the bit. Held at 0 in IDLE and CHECK.
- **bit_cnt:** counts data bits 0..DATA_WIDTH-1 in DATA.
- **armed flag:**
  - Set by any cycle in IDLE with RX_IN=1.
  - Cleared on leaving IDLE.
  - IDLE accepts a start only when armed=1 and RX_IN=0. The detection cycle is D.
  - START is entered in cycle D+1 with edge_cnt=0.
- **Sampling and vote:**
  - RX_IN is captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - At the clock edge ending the PRESCALE/2+1 cycle, sample_out_reg is loaded with the 2-of-3 majority.
  - In the same edge, the strobe for the current field is registered high for exactly one cycle.
  - The datapath therefore sees the new sample and its strobe in the same cycle.
- **START:**
  - Majority 0: stay to the end of the bit, then go to DATA. No strobe is issued.
  - Majority 1: pulse start_glitch, go to IDLE with armed=0.
- **DATA:** SIPO_EN once per bit. After bit DATA_WIDTH-1 completes, go to PARITY.
- **PARITY:** PAR_CHECK_EN at mid-bit. At the end of the bit, go to STOP.
- **STOP:**
  - STOP_CHECK_EN at mid-bit.
  - Go to CHECK in the cycle after the strobe, without waiting for the end of the bit. This allows back-to-back frames.
- **CHECK:** RX_CHECK_EN high for this one cycle, then go to IDLE with armed=0.
  - A low (erroneous) stop bit therefore cannot retrigger a frame until the line returns high.
- The block does no error judgement; parity and stop results belong to the datapath.
- **Reset (async, any state):**
  - State IDLE; counters 0; armed=0.
  - sample_out_reg=1; all strobes, start_glitch and busy = 0.
  - A frame in progress is abandoned and its remaining strobes are never issued.

## Timing
- Definition: M = PRESCALE/2 + 3.
- Relative to detection cycle D:
  - SIPO_EN for data bit i (0-based) is high in cycle D + M + PRESCALE·(i+1).
  - PAR_CHECK_EN is high in cycle D + M + PRESCALE·(DATA_WIDTH+1).
  - STOP_CHECK_EN is high in cycle D + M + PRESCALE·(DATA_WIDTH+2).
  - RX_CHECK_EN follows STOP_CHECK_EN by exactly one cycle.
  - The start glitch decision is made in cycle D+M-1; start_glitch pulses in D+M.
- Defaults (DATA_WIDTH=4, PRESCALE=8), cycles from D:

  | Strobe | Cycles |
  |---|---|
  | SIPO_EN | D+15, D+23, D+31, D+39 |
  | PAR_CHECK_EN | D+47 |
  | STOP_CHECK_EN | D+55 |
  | RX_CHECK_EN | D+56 |

  IDLE is re-entered at D+57.
- busy rises in D+1 and falls in the cycle IDLE is re-entered.
- sample_out_reg holds its value between updates.
- Strobes are mutually exclusive and never high for two consecutive cycles.
  - The only adjacency is STOP_CHECK_EN followed by RX_CHECK_EN.
- A single-cycle RX_IN glitch inside any 3-sample window does not change the voted value.
- Earliest next frame: detection in the first cycle of IDLE with RX_IN=0, provided at least one armed cycle has already occurred.

## Test plan
- **Clean frame:** data 4'b1010, parity 1, stop 1, PRESCALE=8.
  - SIPO_EN at D+15/23/31/39 with sample_out_reg 0,1,0,1.
  - PAR_CHECK_EN at D+47 with sample 1.
  - STOP_CHECK_EN at D+55 with sample 1.
  - RX_CHECK_EN at D+56; busy low at D+57.
- **Start glitch:** RX_IN low for 3 cycles, then high.
  - start_glitch pulses once.
  - No SIPO/PAR/STOP/RX_CHECK strobes.
  - State back to IDLE; the next start requires RX_IN=1 first.
- **Stop error:** stop bit 0, line held low 20 cycles after the frame.
  - STOP_CHECK_EN with sample 0, then RX_CHECK_EN.
  - No new frame until RX_IN goes high; the first falling edge after that starts a normal frame.
- **Vote robustness:** single-cycle inverted pulse at edge_cnt=PRESCALE/2 in each data bit.
  - Voted data is unchanged (4'b1010).
  - Strobe timing is unchanged.
- **Back-to-back:** second start bit begins 1 cycle after RX_CHECK_EN.
  - Second frame is detected.
  - Strobes are offset by exactly (frame length in cycles) from the first frame.
- **Reset mid-frame:** assert rst after the 2nd SIPO_EN.
  - All outputs 0, sample_out_reg=1 immediately (asynchronous).
  - After release, no residual strobes; a fresh frame decodes normally.
